// File: rtl/rot_ensemble_gather_y_if.sv
// LUT-readout and ensemble-handoff bundle for the Y-channel rotation gather stage.
// Slave is the gather block; master is whoever drives LUT beats and consumes groups.
interface rot_ensemble_gather_y_if #(
  parameter int W     = 11,
  parameter int GRP_W = 16
);
  logic                 lut_valid;
  logic                 lut_ready;
  logic [1:0]           lut_rot;
  logic signed [W-1:0]  lut_out1, lut_out2, lut_out3, lut_out4;
  logic signed [W-1:0]  out1_R, out2_R, out3_R, out4_R;
  logic signed [W-1:0]  out1_L, out2_L, out3_L, out4_L;
  logic signed [W-1:0]  out1_U, out2_U, out3_U, out4_U;
  logic signed [W-1:0]  out1_D, out2_D, out3_D, out4_D;
  logic                 ens_valid;
  logic                 ens_ready;
  logic                 seq_err;
  logic [GRP_W-1:0]     grp_cnt;

  modport slave (
    input  lut_valid, lut_rot, lut_out1, lut_out2, lut_out3, lut_out4, ens_ready,
    output lut_ready, ens_valid, seq_err, grp_cnt,
           out1_R, out2_R, out3_R, out4_R, out1_L, out2_L, out3_L, out4_L,
           out1_U, out2_U, out3_U, out4_U, out1_D, out2_D, out3_D, out4_D
  );

  modport master (
    output lut_valid, lut_rot, lut_out1, lut_out2, lut_out3, lut_out4, ens_ready,
    input  lut_ready, ens_valid, seq_err, grp_cnt,
           out1_R, out2_R, out3_R, out4_R, out1_L, out2_L, out3_L, out4_L,
           out1_U, out2_U, out3_U, out4_U, out1_D, out2_D, out3_D, out4_D
  );
endinterface

// File: rtl/rot_ensemble_gather_y.sv
// Gathers R,L,U,D LUT beats into four held banks and hands the full group to the ensemble adder.
// Latency: D beat accepted at edge k -> ens_valid in cycle k+1; lut_ready drops while FULL and ens_ready=0.
module rot_ensemble_gather_y #(
  parameter int W     = 11,
  parameter int GRP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rot_ensemble_gather_y_if.slave bus
);
  typedef enum logic {COLLECT, FULL} state_t;

  state_t              state, state_n;
  logic [1:0]          cnt, cnt_n, exp_rot, wr_idx;
  logic                wr_en, err_set, handoff, accept;
  logic                seq_err_q;
  logic [GRP_W-1:0]    grp_q;
  logic signed [W-1:0] bank [4][4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= 2'd0;
      seq_err_q <= 1'b0;
      grp_q     <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          bank[i][j] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (err_set) seq_err_q <= 1'b1;
      if (handoff) grp_q <= grp_q + 1'b1;
      if (wr_en) begin
        bank[wr_idx][0] <= bus.lut_out1;
        bank[wr_idx][1] <= bus.lut_out2;
        bank[wr_idx][2] <= bus.lut_out3;
        bank[wr_idx][3] <= bus.lut_out4;
      end
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    wr_en         = 1'b0;
    wr_idx        = 2'd0;
    err_set       = 1'b0;
    handoff       = 1'b0;
    bus.lut_ready = (state == COLLECT) || bus.ens_ready;
    accept        = bus.lut_valid && bus.lut_ready;
    // A beat arriving on the handoff edge starts the next group from R.
    exp_rot       = (state == FULL) ? 2'd0 : cnt;
    if (state == FULL && bus.ens_ready) begin
      handoff = 1'b1;
      state_n = COLLECT;
      cnt_n   = 2'd0;
    end
    if (accept) begin
      if (bus.lut_rot == exp_rot) begin
        wr_en  = 1'b1;
        wr_idx = exp_rot;
        if (exp_rot == 2'd3) begin
          cnt_n   = 2'd0;
          state_n = FULL;
        end else begin
          cnt_n = exp_rot + 2'd1;
        end
      end else if (bus.lut_rot == 2'd0) begin
        err_set = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = 2'd0;
        cnt_n   = 2'd1;
      end else begin
        err_set = 1'b1;
        cnt_n   = 2'd0;
      end
    end
  end

  assign bus.ens_valid = (state == FULL);
  assign bus.seq_err   = seq_err_q;
  assign bus.grp_cnt   = grp_q;

  assign bus.out1_R = bank[0][0];
  assign bus.out2_R = bank[0][1];
  assign bus.out3_R = bank[0][2];
  assign bus.out4_R = bank[0][3];
  assign bus.out1_L = bank[1][0];
  assign bus.out2_L = bank[1][1];
  assign bus.out3_L = bank[1][2];
  assign bus.out4_L = bank[1][3];
  assign bus.out1_U = bank[2][0];
  assign bus.out2_U = bank[2][1];
  assign bus.out3_U = bank[2][2];
  assign bus.out4_U = bank[2][3];
  assign bus.out1_D = bank[3][0];
  assign bus.out2_D = bank[3][1];
  assign bus.out3_D = bank[3][2];
  assign bus.out4_D = bank[3][3];
endmodule

// File: tb/tb_rot_ensemble_gather_y.sv
// Randomized and directed bench for rot_ensemble_gather_y against a beat-level reference model.
// A second, narrow-counter instance shares the stimulus to exercise grp_cnt wrap cheaply.
module tb_rot_ensemble_gather_y;
  localparam int W = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rot_ensemble_gather_y_if #(.W(W), .GRP_W(16)) bus ();
  rot_ensemble_gather_y_if #(.W(W), .GRP_W(4))  wbus ();

  rot_ensemble_gather_y #(.W(W), .GRP_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  rot_ensemble_gather_y #(.W(W), .GRP_W(4))  wdut (.clk(clk), .rst_n(rst_n), .bus(wbus));

  assign wbus.lut_valid = bus.lut_valid;
  assign wbus.lut_rot   = bus.lut_rot;
  assign wbus.lut_out1  = bus.lut_out1;
  assign wbus.lut_out2  = bus.lut_out2;
  assign wbus.lut_out3  = bus.lut_out3;
  assign wbus.lut_out4  = bus.lut_out4;
  assign wbus.ens_ready = bus.ens_ready;

  logic signed [W-1:0] dbank [4][4];
  assign dbank[0] = '{bus.out1_R, bus.out2_R, bus.out3_R, bus.out4_R};
  assign dbank[1] = '{bus.out1_L, bus.out2_L, bus.out3_L, bus.out4_L};
  assign dbank[2] = '{bus.out1_U, bus.out2_U, bus.out3_U, bus.out4_U};
  assign dbank[3] = '{bus.out1_D, bus.out2_D, bus.out3_D, bus.out4_D};

  int n_vec  = 0;
  int n_fail = 0;

  // Reference: banks, how many in-order rotations of the current group are held, group ready flag.
  int  m_bank [4][4];
  int  m_have;
  bit  m_full;
  bit  m_err;
  int  m_grp;
  bit  last_acc;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m_bank[i][j] = 0;
    m_have = 0; m_full = 0; m_err = 0; m_grp = 0;
  endtask

  task automatic model_edge();
    bit rdy, acc;
    int r;
    int v [4];
    acc = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = !m_full || bus.ens_ready;
      acc = bus.lut_valid && rdy;
      if (m_full && bus.ens_ready) begin
        m_full = 0;
        m_grp++;
      end
      if (acc) begin
        r = int'(bus.lut_rot);
        v = '{int'(bus.lut_out1), int'(bus.lut_out2), int'(bus.lut_out3), int'(bus.lut_out4)};
        if (r == m_have) begin
          m_bank[r] = v;
          m_have++;
          if (m_have == 4) begin m_have = 0; m_full = 1; end
        end else if (r == 0) begin
          m_err = 1; m_bank[0] = v; m_have = 1;
        end else begin
          m_err = 1; m_have = 0;
        end
      end
    end
    last_acc = acc;
  endtask

  task automatic check_state();
    chk("ens_valid", bus.ens_valid, m_full);
    chk("seq_err", bus.seq_err, m_err);
    chk("grp_cnt", bus.grp_cnt, m_grp % 65536);
    chk("grp_cnt_w4", wbus.grp_cnt, m_grp % 16);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("bank%0d_out%0d", i, j + 1), dbank[i][j], m_bank[i][j]);
  endtask

  task automatic cyc();
    #1;
    chk("lut_ready", bus.lut_ready, (!m_full || bus.ens_ready) ? 1 : 0);
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic set_beat(input int r, input int a, input int b, input int c, input int d);
    bus.lut_valid = 1'b1;
    bus.lut_rot   = 2'(r);
    bus.lut_out1  = W'(a);
    bus.lut_out2  = W'(b);
    bus.lut_out3  = W'(c);
    bus.lut_out4  = W'(d);
  endtask

  task automatic beat(input int r, input int a, input int b, input int c, input int d);
    set_beat(r, a, b, c, d);
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (last_acc) begin
        bus.lut_valid = 1'b0;
        return;
      end
    end
    chk("beat_timeout", 0, 1);
    bus.lut_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic group(input int base);
    for (int r = 0; r < 4; r++)
      beat(r, base + r, base - r, -base, r);
  endtask

  initial begin
    bit hold;
    model_reset();
    bus.lut_valid = 1'b0; bus.lut_rot = 2'd0; bus.ens_ready = 1'b0;
    bus.lut_out1 = '0; bus.lut_out2 = '0; bus.lut_out3 = '0; bus.lut_out4 = '0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("rst_ens_valid", bus.ens_valid, 0);
    chk("rst_grp_cnt", bus.grp_cnt, 0);

    // Happy path
    bus.ens_ready = 1'b1;
    beat(0, 100, 200, 300, 400);
    beat(1, -5, -6, -7, -8);
    beat(2, 1, 2, 3, 4);
    beat(3, 1023, -1024, 0, 7);
    chk("hp_valid", bus.ens_valid, 1);
    chk("hp_out2_L", bus.out2_L, -6);
    chk("hp_out1_D", bus.out1_D, 1023);
    chk("hp_out2_D", bus.out2_D, -1024);
    chk("hp_out4_R", bus.out4_R, 400);
    cyc();
    chk("hp_valid_drop", bus.ens_valid, 0);
    chk("hp_grp", bus.grp_cnt, 1);
    chk("hp_err", bus.seq_err, 0);

    // Back-pressure with an R beat waiting
    bus.ens_ready = 1'b0;
    group(20);
    set_beat(0, 50, 51, 52, 53);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_ready", bus.lut_ready, 0);
      chk("bp_hold_R", bus.out1_R, 20);
    end
    bus.ens_ready = 1'b1;
    cyc();
    bus.lut_valid = 1'b0;
    chk("bp_acc", last_acc, 1);
    chk("bp_new_R", bus.out1_R, 50);
    chk("bp_grp", bus.grp_cnt, 2);

    // Order violation: R, L, D
    do_reset();
    beat(0, 1, 1, 1, 1);
    beat(1, 2, 2, 2, 2);
    beat(3, 3, 3, 3, 3);
    chk("ov_err", bus.seq_err, 1);
    chk("ov_D_discard", bus.out1_D, 0);
    group(7);
    cyc();
    chk("ov_grp", bus.grp_cnt, 1);

    // Resync: R, L, R(9), L, U, D
    do_reset();
    bus.ens_ready = 1'b0;
    beat(0, 1, 1, 1, 1);
    beat(1, 2, 2, 2, 2);
    beat(0, 9, 9, 9, 9);
    beat(1, 4, 4, 4, 4);
    beat(2, 5, 5, 5, 5);
    beat(3, 6, 6, 6, 6);
    chk("rs_valid", bus.ens_valid, 1);
    chk("rs_out1_R", bus.out1_R, 9);
    bus.ens_ready = 1'b1;
    cyc();
    cyc();
    chk("rs_grp", bus.grp_cnt, 1);
    chk("rs_err", bus.seq_err, 1);

    // Reset mid-group
    do_reset();
    beat(0, 1, 1, 1, 1);
    beat(1, 2, 2, 2, 2);
    do_reset();
    chk("rm_out1_R", bus.out1_R, 0);
    chk("rm_out1_L", bus.out1_L, 0);
    chk("rm_valid", bus.ens_valid, 0);
    beat(2, 3, 3, 3, 3);
    beat(3, 4, 4, 4, 4);
    cyc();
    chk("rm_err", bus.seq_err, 1);
    chk("rm_valid2", bus.ens_valid, 0);
    chk("rm_grp", bus.grp_cnt, 0);

    // Randomized traffic, upstream holds a stalled beat
    do_reset();
    hold = 0;
    for (int k = 0; k < 800; k++) begin
      if (!hold) begin
        if ($urandom_range(3) != 0) begin
          set_beat(($urandom_range(5) == 0) ? int'($urandom_range(3)) : m_have,
                   int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024,
                   int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024);
        end else begin
          bus.lut_valid = 1'b0;
        end
      end
      bus.ens_ready = ($urandom_range(1) == 1);
      cyc();
      hold = bus.lut_valid && !last_acc;
    end
    bus.lut_valid = 1'b0;

    // Counter wrap on the 4-bit instance, plus 16 deliveries on the main one
    do_reset();
    bus.ens_ready = 1'b1;
    for (int g = 0; g < 16; g++)
      group(g * 3);
    cyc();
    chk("wrap_w4", wbus.grp_cnt, 0);
    chk("wrap_main", bus.grp_cnt, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
